// File: rtl/pmp_region_writer.sv
// IO-PMP programming front end: turns "protect 2^n bytes at base" requests into
// NA4 / NAPOT / TOR-pair pmpaddr+pmpcfg entries, honouring lock rules.
module pmp_region_writer #(
  parameter int PLEN           = 56,
  parameter int PMP_LEN        = 54,
  parameter int NR_ENTRIES     = 16,
  parameter int PMPGranularity = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [$clog2(NR_ENTRIES)-1:0]   req_idx_i,
  input  logic [PLEN-1:0]                 req_base_i,
  input  logic [$clog2(PLEN):0]           req_size_log2_i,
  input  logic [2:0]                      req_perm_i,
  input  logic                            req_lock_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [1:0]                      rsp_status_o,
  output logic [1:0]                      rsp_mode_o,
  output logic [NR_ENTRIES*PMP_LEN-1:0]   conf_addr_o,
  output logic [NR_ENTRIES*2-1:0]         conf_mode_o,
  output logic [NR_ENTRIES*3-1:0]         conf_perm_o,
  output logic [NR_ENTRIES-1:0]           conf_lock_o
);

  localparam int IW = $clog2(NR_ENTRIES);
  localparam int NW = $clog2(PLEN) + 1;
  localparam int AW = PLEN + 1;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_TOR   = 2'd1;
  localparam logic [1:0] M_NA4   = 2'd2;
  localparam logic [1:0] M_NAPOT = 2'd3;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_LOCKED    = 2'd1;
  localparam logic [1:0] ST_BAD_SIZE  = 2'd2;
  localparam logic [1:0] ST_BAD_ALIGN = 2'd3;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CHECK    = 3'd1;
  localparam logic [2:0] S_WR_PREV  = 3'd2;
  localparam logic [2:0] S_WR_ENTRY = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  localparam logic [AW-1:0] GRAN_MASK = (AW'(1) << (PMPGranularity + 2)) - AW'(1);
  localparam bit            NA4_OK    = (PMPGranularity <= 2);

  function automatic logic [PMP_LEN-1:0] to_pmpaddr(input logic [AW-1:0] byte_addr);
    logic [AW-1:0] shifted;
    shifted = byte_addr >> 2;
    return shifted[PMP_LEN-1:0];
  endfunction

  logic [2:0]         state;
  logic [IW-1:0]      idx_q;
  logic [PLEN-1:0]    base_q;
  logic [NW-1:0]      n_q;
  logic [2:0]         perm_q;
  logic               lock_req_q;

  logic [PMP_LEN-1:0] addr_p;
  logic [PMP_LEN-1:0] prev_addr_p;
  logic [1:0]         mode_p;
  logic               two_p;
  logic               off_p;

  logic [1:0]         rsp_status_q;
  logic [1:0]         rsp_mode_q;

  logic [PMP_LEN-1:0] bank_addr [NR_ENTRIES];
  logic [1:0]         bank_mode [NR_ENTRIES];
  logic [2:0]         bank_perm [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] bank_lock;

  logic [NR_ENTRIES-1:0] is_tor;
  logic [NR_ENTRIES-1:0] addr_locked;
  logic [IW-1:0]      idx_prev;

  logic [AW-1:0]      base_x, pow, end_x, size_mask, napot_ones;
  logic [1:0]         c_status, c_mode;
  logic [PMP_LEN-1:0] c_addr, c_prev_addr;
  logic               c_two, c_off;

  assign idx_prev = idx_q - IW'(1);

  // An address register is frozen by its own L bit, or by the next entry's
  // L bit when that entry uses it as the TOR lower bound.
  always_comb begin
    for (int i = 0; i < NR_ENTRIES; i++) is_tor[i] = (bank_mode[i] == M_TOR);
    addr_locked = bank_lock | {1'b0, bank_lock[NR_ENTRIES-1:1] & is_tor[NR_ENTRIES-1:1]};
  end

  always_comb begin
    base_x      = {1'b0, base_q};
    pow         = AW'(1) << n_q;
    end_x       = base_x + pow;
    size_mask   = pow - AW'(1);
    napot_ones  = (AW'(1) << (n_q - NW'(3))) - AW'(1);
    c_status    = ST_OK;
    c_mode      = M_OFF;
    c_addr      = '0;
    c_prev_addr = '0;
    c_two       = 1'b0;
    c_off       = 1'b0;
    if (n_q == '0) begin
      c_off = 1'b1;
    end else if (n_q > NW'(PLEN)) begin
      c_status = ST_BAD_SIZE;
    end else if (n_q == NW'(2)) begin
      if (NA4_OK) begin
        c_mode = M_NA4;
        c_addr = to_pmpaddr(base_x);
      end else begin
        c_status = ST_BAD_SIZE;
      end
    end else if (n_q == NW'(1) || n_q == NW'(3) || n_q < NW'(PMPGranularity + 2)) begin
      c_status = ST_BAD_SIZE;
    end else if ((base_x & size_mask) == '0) begin
      c_mode = M_NAPOT;
      c_addr = to_pmpaddr(base_x) | napot_ones[PMP_LEN-1:0];
    end else if (((base_x | end_x) & GRAN_MASK) != '0) begin
      c_status = ST_BAD_ALIGN;
    end else if (end_x[PLEN]) begin
      c_status = ST_BAD_SIZE;
    end else if (idx_q == '0) begin
      // base==0 is always NAPOT-aligned, so a TOR at entry 0 can never be exact.
      c_status = ST_BAD_ALIGN;
    end else begin
      c_mode      = M_TOR;
      c_two       = 1'b1;
      c_prev_addr = to_pmpaddr(base_x);
      c_addr      = to_pmpaddr(end_x);
    end
    if (c_status == ST_OK && (addr_locked[idx_q] || (c_two && addr_locked[idx_prev]))) begin
      c_status = ST_LOCKED;
    end
  end

  // Control FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      rsp_status_q <= ST_OK;
      rsp_mode_q   <= M_OFF;
    end else begin
      case (state)
        S_IDLE:     if (req_valid_i) state <= S_CHECK;
        S_CHECK: begin
          rsp_status_q <= c_status;
          rsp_mode_q   <= (c_status == ST_OK) ? c_mode : M_OFF;
          if (c_status != ST_OK) state <= S_RESP;
          else if (c_two)        state <= S_WR_PREV;
          else                   state <= S_WR_ENTRY;
        end
        S_WR_PREV:  state <= S_WR_ENTRY;
        S_WR_ENTRY: state <= S_RESP;
        S_RESP:     if (rsp_ready_i) state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  // Request capture and encoded write data
  always_ff @(posedge clk_i) begin
    if (state == S_IDLE && req_valid_i) begin
      idx_q      <= req_idx_i;
      base_q     <= req_base_i;
      n_q        <= req_size_log2_i;
      perm_q     <= req_perm_i;
      lock_req_q <= req_lock_i;
    end
    if (state == S_CHECK) begin
      addr_p      <= c_addr;
      prev_addr_p <= c_prev_addr;
      mode_p      <= c_mode;
      two_p       <= c_two;
      off_p       <= c_off;
    end
  end

  // Entry bank
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        bank_addr[i] <= '0;
        bank_mode[i] <= M_OFF;
        bank_perm[i] <= '0;
      end
      bank_lock <= '0;
    end else if (state == S_WR_PREV) begin
      bank_addr[idx_prev] <= prev_addr_p;
      bank_mode[idx_prev] <= M_OFF;
      bank_perm[idx_prev] <= '0;
    end else if (state == S_WR_ENTRY) begin
      bank_mode[idx_q] <= mode_p;
      bank_lock[idx_q] <= lock_req_q;
      if (!off_p) begin
        bank_addr[idx_q] <= addr_p;
        bank_perm[idx_q] <= perm_q;
      end
      if (two_p) bank_lock[idx_prev] <= lock_req_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NR_ENTRIES; i++) begin
      conf_addr_o[i*PMP_LEN +: PMP_LEN] = bank_addr[i];
      conf_mode_o[i*2 +: 2]             = bank_mode[i];
      conf_perm_o[i*3 +: 3]             = bank_perm[i];
    end
  end

  assign conf_lock_o  = bank_lock;
  assign req_ready_o  = (state == S_IDLE);
  assign rsp_valid_o  = (state == S_RESP);
  assign rsp_status_o = rsp_status_q;
  assign rsp_mode_o   = rsp_mode_q;

endmodule

// File: tb/tb_pmp_region_writer.sv
// Bench for pmp_region_writer: directed plus random requests against an
// arithmetic model of the entry bank and encoding rules.
module tb_pmp_region_writer;
  localparam int PLEN = 56;
  localparam int PMP_LEN = 54;
  localparam int NR = 16;
  localparam longint unsigned PMASK = (64'd1 << PMP_LEN) - 1;
  localparam longint unsigned TOP   = 64'd1 << PLEN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 req_valid, req_ready;
  logic [3:0]           req_idx;
  logic [PLEN-1:0]      req_base;
  logic [6:0]           req_size;
  logic [2:0]           req_perm;
  logic                 req_lock;
  logic                 rsp_valid, rsp_ready;
  logic [1:0]           rsp_status, rsp_mode;
  logic [NR*PMP_LEN-1:0] conf_addr;
  logic [NR*2-1:0]      conf_mode;
  logic [NR*3-1:0]      conf_perm;
  logic [NR-1:0]        conf_lock;

  pmp_region_writer #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR), .PMPGranularity(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_idx_i(req_idx),
    .req_base_i(req_base), .req_size_log2_i(req_size), .req_perm_i(req_perm),
    .req_lock_i(req_lock), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_status_o(rsp_status), .rsp_mode_o(rsp_mode),
    .conf_addr_o(conf_addr), .conf_mode_o(conf_mode), .conf_perm_o(conf_perm),
    .conf_lock_o(conf_lock)
  );

  int errors = 0;
  int checks = 0;

  longint unsigned m_addr [NR];
  int              m_mode [NR];
  int              m_perm [NR];
  bit              m_lock [NR];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_addr[i] = 0; m_mode[i] = 0; m_perm[i] = 0; m_lock[i] = 0;
    end
  endtask

  function automatic bit m_locked(input int i);
    if (m_lock[i]) return 1'b1;
    if (i + 1 < NR && m_lock[i+1] && m_mode[i+1] == 1) return 1'b1;
    return 1'b0;
  endfunction

  // Status 0 OK,1 LOCKED,2 BAD_SIZE,3 BAD_ALIGN; mode 0 OFF,1 TOR,2 NA4,3 NAPOT.
  task automatic model_req(input int idx, input longint unsigned base, input int n,
                           input int perm, input bit lk, output int st, output int md);
    longint unsigned pow, a, pa, e;
    bit two, off;
    st = 0; md = 0; two = 0; off = 0; a = 0; pa = 0;
    if (n == 0) off = 1;
    else if (n > PLEN) st = 2;
    else if (n == 2) begin md = 2; a = base / 4; end
    else if (n < 4) st = 2;
    else begin
      pow = 64'd1 << n;
      e = base + pow;
      if (base % pow == 0) begin
        md = 3;
        a = ((base / 4) | ((64'd1 << (n - 3)) - 1)) & PMASK;
      end else if (base % 16 != 0 || e % 16 != 0) st = 3;
      else if (e > TOP) st = 2;
      else if (idx == 0) st = 3;
      else begin md = 1; two = 1; pa = base / 4; a = (e / 4) & PMASK; end
    end
    if (st == 0 && (m_locked(idx) || (two && m_locked(idx - 1)))) st = 1;
    if (st != 0) begin
      md = 0;
      return;
    end
    if (two) begin
      m_addr[idx-1] = pa; m_mode[idx-1] = 0; m_perm[idx-1] = 0; m_lock[idx-1] = lk;
    end
    m_mode[idx] = md;
    m_lock[idx] = lk;
    if (!off) begin m_addr[idx] = a; m_perm[idx] = perm; end
  endtask

  task automatic check_conf(input string tag);
    logic [NR*2-1:0] em;
    logic [NR*3-1:0] ep;
    logic [NR-1:0]   el;
    for (int i = 0; i < NR; i++) begin
      check($sformatf("%s addr[%0d]", tag, i), conf_addr[i*PMP_LEN +: PMP_LEN], m_addr[i]);
      em[i*2 +: 2] = 2'(m_mode[i]);
      ep[i*3 +: 3] = 3'(m_perm[i]);
      el[i]        = m_lock[i];
    end
    check({tag, " mode"}, conf_mode, em);
    check({tag, " perm"}, conf_perm, ep);
    check({tag, " lock"}, conf_lock, el);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    model_reset();
    #2;
    check_conf("reset");
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset req_ready", req_ready, 1'b1);
    check("reset rsp_status", rsp_status, 2'd0);
    check("reset rsp_mode", rsp_mode, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_req(input string tag, input int idx, input longint unsigned base, input int n,
                        input int perm, input bit lk, input int hold, input bit intrude,
                        input int exp_st, input int exp_md);
    int st, md, lat, cyc, exp_lat;
    @(negedge clk);
    check({tag, " req_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_idx = 4'(idx); req_base = PLEN'(base); req_size = 7'(n);
    req_perm = 3'(perm); req_lock = lk; rsp_ready = (hold == 0);
    @(posedge clk);
    model_req(idx, base, n, perm, lk, st, md);
    cyc = 0; lat = 0;
    while (lat == 0 && cyc < 20) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) lat = cyc + 1;
      else begin @(posedge clk); cyc++; end
    end
    exp_lat = (st != 0) ? 2 : (md == 1) ? 4 : 3;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " status"}, rsp_status, st);
    check({tag, " mode"}, rsp_mode, md);
    if (exp_st >= 0) check({tag, " status const"}, rsp_status, exp_st);
    if (exp_md >= 0) check({tag, " mode const"}, rsp_mode, exp_md);
    check_conf(tag);
    for (int h = 0; h < hold; h++) begin
      if (intrude) begin
        req_valid = 1'b1; req_idx = 4'((idx + 1) % NR); req_size = 7'd0; req_lock = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold rsp_valid"}, rsp_valid, 1'b1);
      check({tag, " hold req_ready"}, req_ready, 1'b0);
      check({tag, " hold status"}, rsp_status, st);
      check({tag, " hold mode"}, rsp_mode, md);
    end
    if (hold > 0) check_conf({tag, " after hold"});
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n, kind, st, md;
    longint unsigned raw, base;
    rst_n = 1'b1; req_valid = 1'b0; req_idx = '0; req_base = '0; req_size = '0;
    req_perm = '0; req_lock = 1'b0; rsp_ready = 1'b1;
    apply_reset();

    do_req("na4", 0, 64'h1000, 2, 3'b011, 0, 0, 0, 0, 2);
    check("na4 addr0 const", conf_addr[0 +: PMP_LEN], 64'h400);
    check("na4 perm0 const", conf_perm[2:0], 3'b011);
    do_req("napot", 1, 64'h8000_0000, 12, 3'b111, 0, 0, 0, 0, 3);
    check("napot addr1 const", conf_addr[1*PMP_LEN +: PMP_LEN], 64'h2000_01FF);
    do_req("tor", 3, 64'h1040, 7, 3'b101, 0, 0, 0, 0, 1);
    check("tor addr2 const", conf_addr[2*PMP_LEN +: PMP_LEN], 64'h410);
    check("tor addr3 const", conf_addr[3*PMP_LEN +: PMP_LEN], 64'h430);
    check("tor mode2/3 const", conf_mode[7:4], 4'b0100);

    do_req("lock set", 5, 64'h10000, 8, 3'b001, 1, 0, 0, 0, 3);
    do_req("lock retry", 5, 64'h20000, 8, 3'b111, 0, 0, 0, 1, 0);
    do_req("tor below napot lock", 4, 64'h3010, 6, 3'b011, 0, 0, 0, 0, 1);
    apply_reset();
    do_req("locked tor", 5, 64'h5010, 6, 3'b011, 1, 0, 0, 0, 1);
    do_req("under locked tor", 4, 64'h2000, 2, 3'b001, 0, 0, 0, 1, 0);

    do_req("n3", 7, 64'h0, 3, 3'b001, 0, 0, 0, 2, 0);
    do_req("misalign", 8, 64'h1044, 7, 3'b001, 0, 0, 0, 3, 0);
    do_req("n too big", 9, 64'h0, 57, 3'b001, 0, 0, 0, 2, 0);
    do_req("backpressure", 9, 64'h40000, 10, 3'b110, 0, 5, 1, 0, 3);

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) n = 0;
      else if (kind == 1) n = $urandom_range(1, 3);
      else if (kind == 2) n = $urandom_range(57, 70);
      else n = $urandom_range(4, 56);
      raw = {$urandom, $urandom};
      raw = (raw & (TOP - 1)) >> $urandom_range(0, 50);
      kind = $urandom_range(0, 2);
      if (kind == 0 && n <= PLEN) base = raw & ~((64'd1 << n) - 1);
      else if (kind == 1) base = raw & ~64'hF;
      else base = raw;
      do_req($sformatf("rand%0d", t), $urandom_range(1, 15), base, n, $urandom_range(0, 7),
             ($urandom_range(0, 15) == 0), $urandom_range(0, 2), 0, -1, -1);
    end

    apply_reset();
    do_req("pre abort", 0, 64'h1000, 2, 3'b011, 0, 0, 0, 0, 2);
    @(negedge clk);
    req_valid = 1'b1; req_idx = 4'd6; req_base = PLEN'(64'h1040); req_size = 7'd7;
    req_perm = 3'b111; req_lock = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_conf("abort");
    check("abort rsp_valid", rsp_valid, 1'b0);
    check("abort req_ready", req_ready, 1'b1);
    check("abort rsp_mode", rsp_mode, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_conf("after abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pmp_region_writer.md
Name: pmp_region_writer

Overview:
- Programming side of the IO-PMP: accepts "protect region (base, 2^n bytes, perms)" requests over a valid/ready handshake.
- Encodes each request into pmpaddr/pmpcfg form (NA4, NAPOT, or a TOR pair), enforces lock rules, and writes it into an internal entry bank.
- The bank drives conf_addr/mode/perm/lock of the downstream per-entry matchers.
- Returns one status response per request.

Parameters:
PLEN, 56, physical address width in bits
PMP_LEN, 54, pmpaddr width in bits (PLEN-2)
NR_ENTRIES, 16, number of PMP entries (>=2)
PMPGranularity, 2, G; generated values must be unchanged by the matcher's G masking

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready
req_idx_i  in  $clog2(NR_ENTRIES)  target entry
req_base_i  in  PLEN  region base byte address
req_size_log2_i  in  $clog2(PLEN)+1  n, region = 2^n bytes; 0 = disable entry
req_perm_i  in  3  {x,w,r}
req_lock_i  in  1  set L bit on written entry(s)
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response ready
rsp_status_o  out  2  0 OK, 1 LOCKED, 2 BAD_SIZE, 3 BAD_ALIGN
rsp_mode_o  out  2  mode written (OFF/TOR/NA4/NAPOT encoding); OFF on error
conf_addr_o  out  NR_ENTRIES*PMP_LEN  packed pmpaddr, entry i at [i*PMP_LEN +: PMP_LEN]
conf_mode_o  out  NR_ENTRIES*2  packed address mode
conf_perm_o  out  NR_ENTRIES*3  packed {x,w,r}
conf_lock_o  out  NR_ENTRIES  L bits

Behaviour:
- Reset (async, rst_ni low): all conf_* = 0 (every entry mode OFF, unlocked). rsp_valid_o=0, rsp_status_o=0, rsp_mode_o=OFF. FSM=IDLE, req_ready_o=1. Reset mid-operation aborts with no partial write visible after reset.
- FSM states: IDLE, CHECK, WR_PREV, WR_ENTRY, RESP.
- IDLE:
  - req_ready_o=1 only here.
  - On req_valid_i&&req_ready_o, register all request fields and go to CHECK.
- CHECK (1 cycle): compute the encoding and status, in this priority order:
  - n==0: mode OFF at idx; perm/addr of idx unchanged.
  - n>PLEN: BAD_SIZE.
  - n==2: NA4 if G<=2, else BAD_SIZE. pmpaddr = base>>2.
  - n in {1,3} or n<G+2 (n!=2): BAD_SIZE.
  - base aligned to 2^n: NAPOT. pmpaddr = (base>>2) | ((1<<(n-3))-1).
  - base not aligned to 2^n: TOR fallback.
    - Requires base and end = base+2^n aligned to 2^(G+2), else BAD_ALIGN.
    - end > 2^PLEN (carry out): BAD_SIZE.
    - idx==0: allowed only if base==0 (single write). Otherwise idx-1 receives pmpaddr base>>2, mode OFF, perm 0.
    - idx receives pmpaddr end>>2, mode TOR.
  - Lock check, for each entry to be written:
    - Entry i addr is locked if lock[i], or if lock[i+1] and mode[i+1]==TOR.
    - Any target locked: LOCKED, no writes at all.
  - Errors go to RESP; TOR with idx>0 goes to WR_PREV; all others go to WR_ENTRY.
- WR_PREV (1 cycle): write entry idx-1, then go to WR_ENTRY.
- WR_ENTRY (1 cycle): write addr, mode, perm and lock(=req_lock_i) of idx; for TOR with idx>0 also set lock of idx-1 to req_lock_i. Then go to RESP.
- Writes commit on the clock edge. Updated conf_* are visible the cycle after the write state; both TOR entries are visible by the time rsp_valid_o rises.
- RESP:
  - rsp_valid_o=1; status and mode are held stable while rsp_ready_i=0.
  - On handshake go to IDLE; req_ready_o returns to 1 the following cycle.
- Latency (accept edge = cycle 0):
  - NA4/NAPOT/OFF: rsp_valid_o in cycle 3.
  - TOR with idx>0: cycle 4.
  - Error: cycle 2.
- The bank is never written outside the WR states; conf_* stay stable during back-pressure.
- Width rules: all address arithmetic is done at PLEN+1 bits to catch carry; pmpaddr values are truncated to PMP_LEN after the >>2 shift.

Test Plan:
- Reset, then req idx0 base 0x1000 n=2 perm=3'b011 -> cycle-3 rsp OK/NA4; conf_addr[0]=0x400, mode NA4, perm 011.
- idx1 base 0x8000_0000 n=12 -> OK/NAPOT; conf_addr[1]=0x2000_01FF.
- idx3 base 0x1040 n=7 -> rsp at cycle 4, OK/TOR; entry2 addr 0x410 mode OFF; entry3 addr 0x430 mode TOR.
- Write idx5 with req_lock_i=1, then re-request idx5 -> LOCKED, entry5 unchanged. Request idx4 TOR (locked entry5 is NAPOT) -> allowed; retry with entry5 TOR -> LOCKED.
- n=3 -> BAD_SIZE. base 0x1044 n=7 -> BAD_ALIGN. Both respond at cycle 2 with no conf change.
- Hold rsp_ready_i=0 for 5 cycles -> rsp stable, req_ready_o=0, second request not accepted. Assert rst_ni in WR_PREV -> all conf_* zero.
